// File: rtl/chiplet_types_pkg.sv
// Shared chiplet link types: the flit carried between endpoints and switch inports.
package chiplet_types_pkg;

  localparam int FLIT_NUM_VCS = 2;
  localparam int FLIT_VC_W    = (FLIT_NUM_VCS > 1) ? $clog2(FLIT_NUM_VCS) : 1;

  typedef struct packed {
    logic [FLIT_VC_W-1:0] vc;
    logic [31:0]          payload;
  } flit_t;

endpackage

// File: rtl/switch_endpoint_tx_pkg.sv
// Types and helpers for the credit-based endpoint transmitter.
package switch_endpoint_tx_pkg;
  import chiplet_types_pkg::*;

  typedef logic [FLIT_VC_W-1:0] vc_t;

  typedef enum logic {
    TX_IDLE,
    TX_ACTIVE
  } tx_state_t;

  typedef struct packed {
    flit_t flit;
    vc_t   vc;
    logic  last;
  } tx_entry_t;

  // Counter must hold the value BUFFER_SIZE itself, hence +1.
  function automatic int credit_w(input int buffer_size);
    return $clog2(buffer_size + 1);
  endfunction

endpackage

// File: rtl/tx_staging_fifo.sv
// Small synchronous FIFO staging endpoint flits ahead of the credit check.
module tx_staging_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic
) (
  input  logic clk,
  input  logic n_rst,
  input  logic push,
  input  T     push_data,
  input  logic pop,
  output T     head,
  output logic full,
  output logic empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  T                 mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // DEPTH is a power of two, so pointer overflow is the modulo wrap.
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/switch_endpoint_tx.sv
// Credit-based wormhole flit transmitter feeding one switch inport.
module switch_endpoint_tx
  import chiplet_types_pkg::*;
  import switch_endpoint_tx_pkg::*;
#(
  parameter int NUM_VCS     = 2,
  parameter int BUFFER_SIZE = 8,
  parameter int FIFO_DEPTH  = 4,
  localparam int CRED_W     = credit_w(BUFFER_SIZE)
) (
  input  logic                           clk,
  input  logic                           n_rst,
  input  flit_t                          tx_flit,
  input  vc_t                            tx_vc,
  input  logic                           tx_last,
  input  logic                           tx_valid,
  output logic                           tx_ready,
  output flit_t                          out,
  output logic                           data_ready_out,
  input  logic [NUM_VCS-1:0]             credit_granted,
  output logic                           packet_sent,
  output logic [NUM_VCS-1:0][CRED_W-1:0] credits,
  output logic                           err_credit_overflow
);

  tx_entry_t push_entry;
  tx_entry_t head;
  logic      fifo_full;
  logic      fifo_empty;
  logic      send;
  vc_t       vc_eff;
  flit_t     send_flit;

  tx_state_t state, state_nxt;
  vc_t       locked_vc, locked_vc_nxt;

  logic [NUM_VCS-1:0][CRED_W-1:0] credits_nxt;
  logic                           ovf_set;

  assign push_entry = '{flit: tx_flit, vc: tx_vc, last: tx_last};
  assign tx_ready   = !fifo_full;

  tx_staging_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (tx_entry_t)
  ) u_fifo (
    .clk       (clk),
    .n_rst     (n_rst),
    .push      (tx_valid),
    .push_data (push_entry),
    .pop       (send),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Stage 0: VC selection and credit gate on the FIFO head
  assign vc_eff = (state == TX_IDLE) ? head.vc : locked_vc;
  assign send   = !fifo_empty && (credits[vc_eff] != '0);

  always_comb begin
    send_flit    = head.flit;
    send_flit.vc = vc_eff;
  end

  always_comb begin
    state_nxt     = state;
    locked_vc_nxt = locked_vc;
    case (state)
      TX_IDLE: begin
        if (!fifo_empty) begin
          locked_vc_nxt = head.vc;
          // A single-flit packet leaves immediately and never enters ACTIVE.
          if (!(send && head.last)) state_nxt = TX_ACTIVE;
        end
      end
      TX_ACTIVE: begin
        if (send && head.last) state_nxt = TX_IDLE;
      end
      default: state_nxt = TX_IDLE;
    endcase
  end

  always_comb begin
    credits_nxt = credits;
    ovf_set     = 1'b0;
    for (int v = 0; v < NUM_VCS; v++) begin
      if (credit_granted[v] && !(send && (vc_eff == vc_t'(v)))) begin
        if (credits[v] == CRED_W'(BUFFER_SIZE)) ovf_set = 1'b1;
        else credits_nxt[v] = credits[v] + CRED_W'(1);
      end else if (!credit_granted[v] && send && (vc_eff == vc_t'(v))) begin
        credits_nxt[v] = credits[v] - CRED_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state               <= TX_IDLE;
      locked_vc           <= '0;
      err_credit_overflow <= 1'b0;
      for (int v = 0; v < NUM_VCS; v++) credits[v] <= CRED_W'(BUFFER_SIZE);
    end else begin
      state     <= state_nxt;
      locked_vc <= locked_vc_nxt;
      credits   <= credits_nxt;
      if (ovf_set) err_credit_overflow <= 1'b1;
    end
  end

  // Stage 1: registered flit toward the switch inport
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      out            <= '0;
      data_ready_out <= 1'b0;
      packet_sent    <= 1'b0;
    end else begin
      data_ready_out <= send;
      packet_sent    <= send && head.last;
      if (send) out <= send_flit;
    end
  end

endmodule

// File: tb/tb_switch_endpoint_tx.sv
// Bench for switch_endpoint_tx: default instance plus a shallow BUFFER_SIZE=2 / FIFO_DEPTH=2 instance.
module tb_switch_endpoint_tx;
  import chiplet_types_pkg::*;
  import switch_endpoint_tx_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic n_rst;

  flit_t tx_flit1, out1, tx_flit2, out2;
  vc_t   tx_vc1, tx_vc2;
  logic  tx_last1, tx_valid1, tx_ready1, dro1, ps1, ovf1;
  logic  tx_last2, tx_valid2, tx_ready2, dro2, ps2, ovf2;
  logic [1:0]      cg1, cg2;
  logic [1:0][3:0] cr1;
  logic [1:0][1:0] cr2;

  switch_endpoint_tx #(.NUM_VCS(2), .BUFFER_SIZE(8), .FIFO_DEPTH(4)) dut1 (
    .clk(clk), .n_rst(n_rst), .tx_flit(tx_flit1), .tx_vc(tx_vc1), .tx_last(tx_last1),
    .tx_valid(tx_valid1), .tx_ready(tx_ready1), .out(out1), .data_ready_out(dro1),
    .credit_granted(cg1), .packet_sent(ps1), .credits(cr1), .err_credit_overflow(ovf1));

  switch_endpoint_tx #(.NUM_VCS(2), .BUFFER_SIZE(2), .FIFO_DEPTH(2)) dut2 (
    .clk(clk), .n_rst(n_rst), .tx_flit(tx_flit2), .tx_vc(tx_vc2), .tx_last(tx_last2),
    .tx_valid(tx_valid2), .tx_ready(tx_ready2), .out(out2), .data_ready_out(dro2),
    .credit_granted(cg2), .packet_sent(ps2), .credits(cr2), .err_credit_overflow(ovf2));

  typedef struct {
    logic [31:0] payload;
    logic        vc;
    logic        last;
  } exp_t;

  typedef struct {
    int          vc;
    int          vc_body;
    int          len;
    logic [31:0] base;
    int          exp_c0;
    int          exp_c1;
  } vec_t;

  exp_t sb1[$];
  exp_t sb2[$];
  logic in_pkt[2];
  logic lock_vc[2];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   pulses[2];
  int   pkts[2];
  int   first_cyc, last_cyc;
  vec_t vt[4];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference wormhole model: the head flit's VC is kept for the whole packet.
  task automatic model_accept(input int d, input flit_t f, input logic vc, input logic last);
    exp_t e;
    if (!in_pkt[d]) lock_vc[d] = vc;
    in_pkt[d] = !last;
    e.payload = f.payload;
    e.vc      = lock_vc[d];
    e.last    = last;
    if (d == 0) sb1.push_back(e);
    else sb2.push_back(e);
  endtask

  task automatic monitor(input int d, input logic dro, input logic ps, input flit_t o);
    exp_t e;
    if (ps && !dro) check($sformatf("dut%0d_sent_without_data", d + 1), ps, 1'b0);
    if (dro) begin
      pulses[d]++;
      if (d == 0) begin
        if (pulses[0] == 1) first_cyc = cyc;
        last_cyc = cyc;
      end
      if ((d == 0 && sb1.size() == 0) || (d == 1 && sb2.size() == 0)) begin
        checks++;
        errors++;
        $display("FAIL dut%0d_unexpected_flit: got payload 0x%0h expected no flit", d + 1, o.payload);
      end else begin
        e = (d == 0) ? sb1.pop_front() : sb2.pop_front();
        check($sformatf("dut%0d_payload", d + 1), o.payload, e.payload);
        check($sformatf("dut%0d_out_vc", d + 1), o.vc, e.vc);
        check($sformatf("dut%0d_packet_sent", d + 1), ps, e.last);
      end
      if (ps) pkts[d]++;
    end
  endtask

  task automatic tick();
    logic a1, a2;
    a1 = tx_valid1 && tx_ready1;
    a2 = tx_valid2 && tx_ready2;
    if (a1) model_accept(0, tx_flit1, tx_vc1, tx_last1);
    if (a2) model_accept(1, tx_flit2, tx_vc2, tx_last2);
    @(posedge clk);
    #1;
    cyc++;
    monitor(0, dro1, ps1, out1);
    monitor(1, dro2, ps2, out2);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Offers one flit and advances until accepted; the flit's own vc field is junk on purpose.
  task automatic send_flit(input int d, input logic [31:0] p, input logic vc, input logic last,
                           output int acc);
    flit_t f;
    f.payload = p;
    f.vc      = ~vc;
    if (d == 0) begin
      tx_flit1 = f; tx_vc1 = vc; tx_last1 = last; tx_valid1 = 1'b1;
    end else begin
      tx_flit2 = f; tx_vc2 = vc; tx_last2 = last; tx_valid2 = 1'b1;
    end
    acc = -1;
    for (int i = 0; i < 40; i++) begin
      logic rdy;
      rdy = (d == 0) ? tx_ready1 : tx_ready2;
      tick();
      if (rdy) begin
        acc = cyc;
        break;
      end
    end
    if (acc < 0) check($sformatf("dut%0d_accept_timeout", d + 1), 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    n_rst = 1'b0;
    tx_valid1 = 1'b0; tx_valid2 = 1'b0; cg1 = '0; cg2 = '0;
    sb1.delete(); sb2.delete();
    in_pkt[0] = 1'b0; in_pkt[1] = 1'b0;
    tick();
    check("rst_tx_ready1", tx_ready1, 1'b1);
    check("rst_data_ready1", dro1, 1'b0);
    check("rst_packet_sent1", ps1, 1'b0);
    check("rst_out1", out1, '0);
    check("rst_credit1_vc0", cr1[0], 8);
    check("rst_credit1_vc1", cr1[1], 8);
    check("rst_overflow1", ovf1, 1'b0);
    check("rst_tx_ready2", tx_ready2, 1'b1);
    check("rst_credit2_vc0", cr2[0], 2);
    n_rst = 1'b1;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, head_acc;
    vt[0] = '{vc: 1, vc_body: 1, len: 3, base: 32'hA000_0001, exp_c0: 8, exp_c1: 5};
    vt[1] = '{vc: 0, vc_body: 1, len: 3, base: 32'hB100_0010, exp_c0: 5, exp_c1: 5};
    vt[2] = '{vc: 1, vc_body: 0, len: 1, base: 32'hC200_0100, exp_c0: 5, exp_c1: 4};
    vt[3] = '{vc: 0, vc_body: 0, len: 2, base: 32'hD300_1000, exp_c0: 3, exp_c1: 4};

    tx_flit1 = '0; tx_vc1 = '0; tx_last1 = 1'b0; tx_valid1 = 1'b0; cg1 = '0;
    tx_flit2 = '0; tx_vc2 = '0; tx_last2 = 1'b0; tx_valid2 = 1'b0; cg2 = '0;
    n_rst = 1'b0;
    #2;
    do_reset();

    foreach (vt[v]) begin
      pulses[0] = 0; pkts[0] = 0; head_acc = 0;
      for (int f = 0; f < vt[v].len; f++) begin
        send_flit(0, vt[v].base + f, (f == 0) ? vt[v].vc[0] : vt[v].vc_body[0],
                  f == vt[v].len - 1, acc);
        if (f == 0) head_acc = acc;
      end
      tx_valid1 = 1'b0;
      ticks(4);
      check($sformatf("vec%0d_flits", v), pulses[0], vt[v].len);
      check($sformatf("vec%0d_packets", v), pkts[0], 1);
      check($sformatf("vec%0d_back_to_back", v), last_cyc - first_cyc, vt[v].len - 1);
      check($sformatf("vec%0d_latency", v), first_cyc - head_acc, 1);
      check($sformatf("vec%0d_credit_vc0", v), cr1[0], vt[v].exp_c0);
      check($sformatf("vec%0d_credit_vc1", v), cr1[1], vt[v].exp_c1);
      check($sformatf("vec%0d_drained", v), sb1.size(), 0);
    end

    // Credit return lands in the same cycle as each send on VC0.
    do_reset();
    pulses[0] = 0;
    for (int i = 0; i < 4; i++) begin
      tx_flit1 = '{vc: 1'b1, payload: 32'hE000_0000 + i};
      tx_vc1 = 1'b0; tx_last1 = (i == 3); tx_valid1 = 1'b1;
      cg1 = (i > 0) ? 2'b01 : 2'b00;
      tick();
    end
    tx_valid1 = 1'b0; cg1 = 2'b01;
    tick();
    cg1 = 2'b00;
    ticks(2);
    check("simul_flits", pulses[0], 4);
    check("simul_credit_vc0", cr1[0], 8);
    check("simul_no_overflow", ovf1, 1'b0);

    // Credit returned to a full counter.
    cg1 = 2'b10;
    tick();
    cg1 = 2'b00;
    check("ovf_credit_vc1", cr1[1], 8);
    check("ovf_set", ovf1, 1'b1);
    ticks(3);
    check("ovf_sticky", ovf1, 1'b1);
    n_rst = 1'b0;
    #1;
    check("ovf_cleared_by_reset", ovf1, 1'b0);
    n_rst = 1'b1;
    tick();

    // Shallow instance: two credits, two FIFO slots, four-flit packet.
    pulses[1] = 0; pkts[1] = 0;
    for (int i = 0; i < 4; i++) send_flit(1, 32'hF000_0000 + i, 1'b0, i == 3, acc);
    tx_valid2 = 1'b0;
    ticks(3);
    check("stall_flits", pulses[1], 2);
    check("stall_fifo_full", tx_ready2, 1'b0);
    check("stall_credit_vc0", cr2[0], 0);
    for (int k = 0; k < 2; k++) begin
      cg2 = 2'b01;
      tick();
      cg2 = 2'b00;
      check($sformatf("resume%0d_not_yet", k), dro2, 1'b0);
      tick();
      check($sformatf("resume%0d_sent", k), dro2, 1'b1);
      check($sformatf("resume%0d_flits", k), pulses[1], 3 + k);
      check($sformatf("resume%0d_tx_ready", k), tx_ready2, 1'b1);
    end
    ticks(2);
    check("resume_packets", pkts[1], 1);
    check("resume_credit_vc0", cr2[0], 0);
    check("resume_credit_vc1", cr2[1], 2);
    check("resume_drained", sb2.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
